// File: rtl/bf_pkg.sv
// ----------------------------------------------------------------------------
// bf_pkg
// Shared definitions for the delay-and-sum beamformer core.
//   - bf_state_e   : frame sequencer states (encoding is visible on debug_state)
//   - CFG_DELAY/APOD: cfg_sel codes selecting the delay or weight register bank
//   - unity_weight : apodization weight that passes a sample unscaled
// ----------------------------------------------------------------------------
package bf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } bf_state_e;

   localparam logic CFG_DELAY = 1'b0;
   localparam logic CFG_APOD  = 1'b1;

   // Weights are fixed point with APOD_W-1 fraction bits, so 1.0 is 2^(APOD_W-1).
   function automatic int unsigned unity_weight(input int unsigned apod_w);
      return 32'd1 << (apod_w - 1);
   endfunction

endpackage

// File: rtl/bf_delay_line.sv
// ----------------------------------------------------------------------------
// bf_delay_line
// One channel's circular sample buffer with a registered, delayed read.
// Ports:
//   clk      in  clock
//   we_i     in  write din_i at waddr_i
//   waddr_i  in  current write pointer
//   din_i    in  live channel sample
//   rd_en_i  in  capture a delayed sample into the output register
//   delay_i  in  read distance behind the write pointer (0 = live sample)
//   dout_o   out registered delayed sample
// ----------------------------------------------------------------------------
module bf_delay_line #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     delay_i,
   output logic [DATA_W-1:0] dout_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_q;
   logic [AW-1:0]     raddr;

   // Pointer arithmetic wraps naturally at DEPTH (power of 2).
   assign raddr = waddr_i - delay_i;

   // The read sees the pre-write contents, so delay 0 must bypass to the
   // live sample; any non-zero delay never aliases the slot being written.
   always_ff @(posedge clk) begin
      if (we_i)    mem_q[waddr_i] <= din_i;
      if (rd_en_i) rd_q <= (delay_i == '0) ? din_i : mem_q[raddr];
   end

   assign dout_o = rd_q;

endmodule

// File: rtl/das_beamformer_core.sv
// ----------------------------------------------------------------------------
// das_beamformer_core
// Delay-and-sum receive beamformer: per-channel programmable delay and
// apodization, one summed beam sample per accepted input sample in RUN.
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   start, frame_len    frame start pulse (IDLE only) and output sample count
//   ch_data, in_valid   packed channel samples and their strobe
//   cfg_we/sel/ch/data  delay/weight register writes (IDLE only)
//   busy                frame in progress
//   out_valid, beamformed_output  beam sample, two cycles after acceptance
//   done                end-of-frame pulse, coincident with the last output
//   debug_state         current sequencer state
// ----------------------------------------------------------------------------
module das_beamformer_core #(
   parameter int DATA_W  = 16,
   parameter int N_CH    = 4,
   parameter int DEPTH   = 256,
   parameter int APOD_W  = 8,
   localparam int OUT_W  = DATA_W + 1 + $clog2(N_CH),
   localparam int CH_W   = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [15:0]            frame_len,
   input  logic [N_CH*DATA_W-1:0] ch_data,
   input  logic                   in_valid,
   input  logic                   cfg_we,
   input  logic                   cfg_sel,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [15:0]            cfg_data,
   output logic                   busy,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       beamformed_output,
   output logic                   done,
   output logic [1:0]             debug_state
);
   import bf_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = DATA_W + APOD_W + 1;   // exact signed x unsigned product
   localparam int ACC_W = PW + CH_W;
   localparam logic [APOD_W-1:0] W_UNITY = APOD_W'(unity_weight(APOD_W));

   bf_state_e          state_q, state_d;
   logic [AW-1:0]      delay_q  [N_CH];
   logic [APOD_W-1:0]  weight_q [N_CH];
   logic [AW-1:0]      wptr_q, pcnt_q, maxd_q, maxd_c, cfg_delay;
   logic [15:0]        flen_q, scnt_q;
   logic               dcnt_q;
   logic [2:1]         vld_pipe_q;
   logic               acc_vld, wr_en;
   logic [OUT_W-1:0]   out_q, sum_c;
   logic [N_CH-1:0][DATA_W-1:0] rd_data;
   logic signed [PW-1:0]    prod_c [N_CH];
   logic signed [ACC_W-1:0] acc_c;

   // Longest programmed delay sets how many samples must be primed.
   always_comb begin
      maxd_c = '0;
      for (int c = 0; c < N_CH; c++)
         if (delay_q[c] > maxd_c) maxd_c = delay_q[c];
   end

   assign cfg_delay = ({16'd0, cfg_data} >= 32'(DEPTH)) ? AW'(DEPTH - 1) : cfg_data[AW-1:0];

   assign wr_en   = in_valid && (state_q == ST_PRIME || state_q == ST_RUN);
   assign acc_vld = in_valid && (state_q == ST_RUN);

   // ---------------- next-state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:
            if (start) begin
               if (maxd_c != '0)          state_d = ST_PRIME;
               else if (frame_len == '0)  state_d = ST_DONE;
               else                       state_d = ST_RUN;
            end
         ST_PRIME:
            if (in_valid && pcnt_q == maxd_q - AW'(1))
               state_d = (flen_q == '0) ? ST_DONE : ST_RUN;
         ST_RUN:
            if (in_valid && scnt_q == flen_q - 16'd1) state_d = ST_DONE;
         ST_DONE:
            if (dcnt_q) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- state, config, counters, pipeline ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         pcnt_q     <= '0;
         scnt_q     <= '0;
         flen_q     <= '0;
         maxd_q     <= '0;
         dcnt_q     <= 1'b0;
         vld_pipe_q <= '0;
         out_q      <= '0;
         for (int c = 0; c < N_CH; c++) begin
            delay_q[c]  <= '0;
            weight_q[c] <= W_UNITY;
         end
      end else begin
         state_q    <= state_d;
         vld_pipe_q <= {vld_pipe_q[1], acc_vld};
         if (vld_pipe_q[1]) out_q <= sum_c;
         // DONE lasts two cycles; this marks the second one.
         dcnt_q     <= (state_q == ST_DONE) && !dcnt_q;
         if (wr_en) wptr_q <= wptr_q + AW'(1);
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_we) begin
                  if (cfg_sel == CFG_DELAY) delay_q[cfg_ch]  <= cfg_delay;
                  else                      weight_q[cfg_ch] <= cfg_data[APOD_W-1:0];
               end
               if (start) begin
                  flen_q <= frame_len;
                  wptr_q <= '0;
                  maxd_q <= maxd_c;
                  pcnt_q <= '0;
                  scnt_q <= '0;
               end
            end
            ST_PRIME: if (in_valid) pcnt_q <= pcnt_q + AW'(1);
            ST_RUN:   if (in_valid) scnt_q <= scnt_q + 16'd1;
            default: ;
         endcase
      end
   end

   // ---------------- per-channel delay lines ----------------
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      bf_delay_line #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dl (
         .clk     (clk),
         .we_i    (wr_en),
         .waddr_i (wptr_q),
         .din_i   (ch_data[g*DATA_W +: DATA_W]),
         .rd_en_i (acc_vld),
         .delay_i (delay_q[g]),
         .dout_o  (rd_data[g])
      );
   end

   // ---------------- weighted sum ----------------
   // Weight is zero-extended so the multiply stays signed; >>> floors.
   always_comb begin
      acc_c = '0;
      for (int c = 0; c < N_CH; c++) begin
         prod_c[c] = $signed({{(APOD_W+1){rd_data[c][DATA_W-1]}}, rd_data[c]}) *
                     $signed({{(DATA_W+1){1'b0}}, weight_q[c]});
         acc_c = acc_c + ACC_W'(prod_c[c] >>> (APOD_W - 1));
      end
      sum_c = acc_c[OUT_W-1:0];
   end

   assign busy              = (state_q != ST_IDLE);
   assign out_valid         = vld_pipe_q[2];
   assign beamformed_output = out_q;
   assign done              = (state_q == ST_DONE) && dcnt_q;
   assign debug_state       = state_q;

endmodule

// File: tb/tb_das_beamformer_core.sv
module tb_das_beamformer_core;
   localparam int N_CH = 4, DATA_W = 16, DEPTH = 256, APOD_W = 8, OUT_W = 19;
   localparam int UNITY = 128;

   logic clk = 1'b0;
   logic reset, start, in_valid, cfg_we, cfg_sel;
   logic [15:0] frame_len, cfg_data;
   logic [1:0]  cfg_ch;
   logic [N_CH*DATA_W-1:0] ch_data;
   logic busy, out_valid, done;
   logic [OUT_W-1:0] beamformed_output;
   logic [1:0] debug_state;

   das_beamformer_core dut (
      .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
      .ch_data(ch_data), .in_valid(in_valid), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_ch(cfg_ch), .cfg_data(cfg_data), .busy(busy), .out_valid(out_valid),
      .beamformed_output(beamformed_output), .done(done), .debug_state(debug_state));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int val; bit last; int cyc; } exp_t;
   exp_t sb[$];
   exp_t me;

   int total = 0, bad = 0;
   int md[N_CH], mw[N_CH], cval[N_CH];
   int hist[N_CH][$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: y = sum over channels of floor(x[n-d] * w / 2^(APOD_W-1)).
   function automatic int beam(input int n);
      int s, p, q;
      s = 0;
      for (int c = 0; c < N_CH; c++) begin
         p = hist[c][n - md[c]] * mw[c];
         q = p / UNITY;
         if (p < 0 && (p % UNITY) != 0) q = q - 1;
         s += q;
      end
      return s;
   endfunction

   function automatic int gen(input int mode, input int c, input int n);
      logic signed [15:0] r;
      case (mode)
         0: return cval[c];
         1: return n;
         default: begin r = 16'($urandom); return int'(r); end
      endcase
   endfunction

   task automatic model_defaults();
      for (int c = 0; c < N_CH; c++) begin md[c] = 0; mw[c] = UNITY; end
   endtask

   // Scoreboard monitor: every DUT output must match the head of the queue.
   always @(negedge clk) begin
      if (reset && out_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got %0d expected no output", $signed(beamformed_output));
         end else begin
            me = sb.pop_front();
            chk("beam_value", int'($signed(beamformed_output)), me.val);
            chk("latency", cyc, me.cyc + 2);
            chk("done_with_last", int'(done), int'(me.last));
         end
      end
   end

   task automatic cfg_write(input bit sel, input int ch, input int data, input bit apply);
      cfg_we = 1'b1; cfg_sel = sel; cfg_ch = 2'(ch); cfg_data = 16'(data);
      @(negedge clk);
      cfg_we = 1'b0;
      if (apply) begin
         if (sel == 1'b0) md[ch] = (data > DEPTH - 1) ? DEPTH - 1 : data;
         else             mw[ch] = data & 255;
      end
   endtask

   task automatic run_frame(input int flen, input int mode, input bit gaps,
                            input bit disturb, input int abort_at);
      int maxd, tot, n, v;
      exp_t e;
      maxd = 0;
      for (int c = 0; c < N_CH; c++) begin
         hist[c].delete();
         if (md[c] > maxd) maxd = md[c];
      end
      start = 1'b1; frame_len = 16'(flen);
      @(negedge clk);
      start = 1'b0;
      chk("state_after_start", int'(debug_state), (maxd != 0) ? 1 : ((flen == 0) ? 3 : 2));
      tot = maxd + flen;
      n = 0;
      while (n < tot) begin
         if (abort_at >= 0 && n == abort_at) begin
            in_valid = 1'b0; reset = 1'b0;
            @(negedge clk);
            chk("rst_busy", int'(busy), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_state", int'(debug_state), 0);
            chk("rst_output", int'(beamformed_output), 0);
            reset = 1'b1;
            sb.delete();
            model_defaults();
            return;
         end
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            ch_data = {$urandom, $urandom};
         end else begin
            in_valid = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
               v = gen(mode, c, n);
               ch_data[c*DATA_W +: DATA_W] = 16'(v);
               hist[c].push_back(v);
            end
            if (n >= maxd) begin
               e.val = beam(n); e.last = (n == tot - 1); e.cyc = cyc;
               sb.push_back(e);
            end
            n++;
         end
         if (disturb && n == maxd + 2) begin
            cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 16'd7; start = 1'b1;
         end
         @(negedge clk);
         cfg_we = 1'b0; start = 1'b0;
      end
      // Extra valid during the drain must be ignored.
      in_valid = 1'b1; ch_data = {$urandom, $urandom};
      @(negedge clk);
      in_valid = 1'b0;
      chk("done_timing", int'(done), 1);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("idle_after_done", int'(debug_state), 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0;
      frame_len = '0; cfg_data = '0; cfg_ch = '0; ch_data = '0;
      model_defaults();
      repeat (3) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_state", int'(debug_state), 0);
      chk("reset_output", int'(beamformed_output), 0);
      reset = 1'b1;
      @(negedge clk);

      // 1: default config, constant 100 -> 400, no priming
      for (int c = 0; c < N_CH; c++) cval[c] = 100;
      run_frame(4, 0, 1'b0, 1'b0, -1);

      // 2: staggered delays with a ramp -> 6, 10, 14
      for (int c = 0; c < N_CH; c++) cfg_write(1'b0, c, c, 1'b1);
      run_frame(3, 1, 1'b0, 1'b0, -1);

      // 3: floor rounding and max weight
      for (int c = 0; c < N_CH; c++) cfg_write(1'b0, c, 0, 1'b1);
      cfg_write(1'b1, 0, 64, 1'b1);
      for (int c = 1; c < N_CH; c++) cfg_write(1'b1, c, 0, 1'b1);
      for (int c = 0; c < N_CH; c++) cval[c] = -3;
      run_frame(2, 0, 1'b0, 1'b0, -1);
      cfg_write(1'b1, 0, 255, 1'b1);
      cval[0] = 32767; cval[1] = 0; cval[2] = 0; cval[3] = 0;
      run_frame(2, 0, 1'b0, 1'b0, -1);

      // 4: full-scale extremes on every channel
      for (int c = 0; c < N_CH; c++) cfg_write(1'b1, c, 255, 1'b1);
      for (int c = 0; c < N_CH; c++) cval[c] = 32767;
      run_frame(2, 0, 1'b0, 1'b0, -1);
      for (int c = 0; c < N_CH; c++) cval[c] = -32768;
      run_frame(2, 0, 1'b0, 1'b0, -1);

      // 5: reset mid-RUN, then frame 1 must repeat with default config
      for (int c = 0; c < N_CH; c++) cfg_write(1'b0, c, c, 1'b1);
      run_frame(10, 2, 1'b0, 1'b0, 6);
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) cval[c] = 100;
      run_frame(4, 0, 1'b0, 1'b0, -1);

      // 6: delay clamp, ignored config/start during RUN, gapped input
      cfg_write(1'b0, 0, 1, 1'b1);
      cfg_write(1'b0, 2, 300, 1'b1);
      cfg_write(1'b0, 3, 5, 1'b1);
      cfg_write(1'b1, 1, 200, 1'b1);
      run_frame(6, 2, 1'b1, 1'b1, -1);

      // 7: zero-length frames, with and without priming
      for (int c = 0; c < N_CH; c++) cfg_write(1'b0, c, 0, 1'b1);
      run_frame(0, 2, 1'b0, 1'b0, -1);
      cfg_write(1'b0, 1, 2, 1'b1);
      run_frame(0, 2, 1'b1, 1'b0, -1);

      // 8: randomized frames
      for (int it = 0; it < 4; it++) begin
         for (int c = 0; c < N_CH; c++) begin
            cfg_write(1'b0, c, $urandom_range(0, 15), 1'b1);
            cfg_write(1'b1, c, $urandom_range(0, 255), 1'b1);
         end
         run_frame($urandom_range(1, 12), 2, 1'b1, 1'($urandom_range(0, 1)), -1);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/das_beamformer_core.md
Name: das_beamformer_core

Overview:
Parametrised delay-and-sum receive beamformer core. It is the next generation of top_bf, generalised in channel count, sample width and delay depth.
- Per-channel circular delay lines with run-time programmable delays and apodization weights.
- Framed start/prime/run/done sequencing.
- Produces one weighted, summed beam sample per accepted input sample.
- Sits between the channel capture front-end and envelope/scan-conversion stages.

Parameters:
DATA_W, 16, signed sample width per channel
N_CH, 4, receive channel count (power of 2, >=2)
DEPTH, 256, delay-line depth per channel (power of 2); max delay DEPTH-1
APOD_W, 8, unsigned apodization weight width; unity = 2^(APOD_W-1)
OUT_W, DATA_W+1+$clog2(N_CH), beam output width (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle frame start pulse; honoured only in IDLE
frame_len  in  16  output samples per frame; latched on start
ch_data  in  N_CH*DATA_W  channel samples, channel c at [c*DATA_W +: DATA_W]
in_valid  in  1  ch_data valid this cycle
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = delay, 1 = apodization
cfg_ch  in  $clog2(N_CH)  target channel
cfg_data  in  16  delay (low $clog2(DEPTH) bits) or weight (low APOD_W bits)
busy  out  1  state != IDLE
out_valid  out  1  beamformed_output valid
beamformed_output  out  OUT_W  signed beam sample
done  out  1  one-cycle end-of-frame pulse
debug_state  out  2  current FSM state encoding

Behaviour:
- Reset (reset==0 at a clock edge) overrides everything:
  - state IDLE; all pointers and counters 0.
  - busy/out_valid/done = 0; beamformed_output = 0; debug_state = 0.
  - All delays = 0; all weights = 2^(APOD_W-1).
  - Delay-line contents need not be cleared.
- FSM encoding: IDLE=0, PRIME=1, RUN=2, DONE=3.
- Config writes:
  - Take effect only in IDLE; ignored in any other state.
  - Delay values >= DEPTH clamp to DEPTH-1.
- IDLE: in_valid is ignored.
  - On start: latch frame_len, clear write pointer, compute max_d = max over channels of delay.
  - If max_d==0 go to RUN, otherwise go to PRIME.
- PRIME:
  - Each in_valid writes all channels at wptr; wptr++ (mod DEPTH); no output.
  - After max_d samples have been written, go to RUN.
- RUN: each in_valid writes sample k and produces output for k.
  - Output: y[k] = sum_c ((x_c[k-d_c] * w_c) >>> (APOD_W-1)).
  - Read address = (wptr - d_c) mod DEPTH.
  - d_c==0 bypasses to the live input sample.
  - Product is signed DATA_W x unsigned APOD_W; arithmetic shift floors.
  - Sum is carried at full OUT_W; no saturation or overflow is possible.
- Pipeline: 2-stage (registered read/bypass, then registered multiply-sum).
  - Sample accepted at cycle t gives out_valid=1 at t+2.
  - Gaps in in_valid stall cleanly; no bubbles are invented.
- RUN exit:
  - Counts accepted samples; on the frame_len-th sample (cycle t) go to DONE.
  - frame_len==0: go to DONE directly from the PRIME/IDLE exit point, with no output.
- DONE:
  - in_valid and start are ignored while the pipeline drains.
  - done=1 at t+2, coincident with the last out_valid; state IDLE at t+3.
  - For frame_len==0, done pulses on the 2nd DONE cycle.
- start while not IDLE: ignored.
- out_valid is 0 outside the output cycles above.

Decomposition:
- Package bf_pkg:
  - state encodings (IDLE/PRIME/RUN/DONE);
  - cfg_sel codes (CFG_DELAY=0, CFG_APOD=1);
  - unity-weight constant function.
- Sub-module bf_delay_line:
  - One per channel via generate.
  - DEPTH x DATA_W, 1 write + 1 registered read port, zero-delay bypass mux.
- The core holds the FSM, config registers, max-delay reduction and multiply-accumulate tree.

Test Plan:
All cases use defaults (N_CH=4, DATA_W=16, DEPTH=256, APOD_W=8).
1. Reset defaults; start with frame_len=4; all channels 100 each cycle -> PRIME skipped; four outputs of 400 at acceptance+2; done with the 4th; busy falls next cycle.
2. Delays {0,1,2,3}, ramp x_c[k]=k, frame_len=3 -> 3 prime samples with no output; outputs 6, 10, 14.
3. Weights {64,0,0,0}, all inputs -3 -> output -2 (floor of -1.5); weight 255 with ch0 only at 32767 -> 65278.
4. All channels 32767 with weight 255 -> 261112; all channels -32768 -> -261120; no wrap in the 19-bit output.
5. Pull reset low mid-RUN -> next cycle debug_state=0, out_valid=0, busy=0; delays read back as 0 (frame 1 behaviour repeats).
6. Delay write 300 clamps to 255 (prime length 255). Config writes and start issued during RUN are ignored. in_valid toggled 1/0 keeps outputs in order with matching gaps.
